// File: rtl/flash_prefetch_cache_pkg.sv
// Shared types and constants for the flash prefetch cache and its tag/data array.
package flash_prefetch_cache_pkg;

  localparam int ADDR_W       = 22;
  localparam int DATA_W       = 16;
  localparam int IDX_BITS_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FILL
  } state_e;

  // Sequential word address; 22'h3FFFFF rolls over to 22'h000000.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/flash_cache_mem.sv
// Direct-mapped tag/valid/data array: one write port, one async read port, single-cycle flush.
module flash_cache_mem
  import flash_prefetch_cache_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rhit,
  output logic [DATA_W-1:0] rdata
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = ADDR_W - IDX_BITS;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_d  [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [DATA_W-1:0]  data_d [ENTRIES];
  logic [IDX_BITS-1:0] widx, ridx;

  // Flush is applied after the write so a coincident fill is left invalid.
  always_comb begin
    widx    = waddr[IDX_BITS-1:0];
    ridx    = raddr[IDX_BITS-1:0];
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d[widx] = 1'b1;
      tag_d[widx]   = waddr[ADDR_W-1:IDX_BITS];
      data_d[widx]  = wdata;
    end
    if (flush) begin
      valid_d = '0;
    end
    rhit  = valid_q[ridx] && (tag_q[ridx] == raddr[ADDR_W-1:IDX_BITS]);
    rdata = data_q[ridx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/flash_prefetch_cache.sv
// CPU-side read cache in front of a slow flash controller, with a single
// next-line prefetch after every demand completion.
module flash_prefetch_cache
  import flash_prefetch_cache_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  input  logic              flush,
  input  logic              flash_ready,
  input  logic              flash_busy,
  input  logic [DATA_W-1:0] flash_dout,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_cs
);

  state_e            state_q;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] flash_addr_q;
  logic              flash_cs_q;
  logic              demand_q;
  logic [ADDR_W-1:0] pf_addr_q;
  logic              pf_pending_q;

  logic [ADDR_W-1:0] lookup_addr;
  logic              mem_hit;
  logic              lookup_hit;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              fill_match;

  // A demand always owns the single read port; otherwise it probes the prefetch target.
  always_comb begin
    lookup_addr = req ? addr : pf_addr_q;
    lookup_hit  = mem_hit && !flush;
    mem_we      = (state_q == ST_WAIT) && !flash_busy;
    fill_match  = req && !ack_q && (addr == flash_addr_q);
  end

  flash_cache_mem #(
    .IDX_BITS (IDX_BITS)
  ) u_mem (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .we     (mem_we),
    .waddr  (flash_addr_q),
    .wdata  (flash_dout),
    .raddr  (lookup_addr),
    .rhit   (mem_hit),
    .rdata  (mem_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      flash_addr_q <= '0;
      flash_cs_q   <= 1'b0;
      demand_q     <= 1'b0;
      pf_addr_q    <= '0;
      pf_pending_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // ack_q blocks re-acceptance of the request still held during its ack cycle.
          if (req && flash_ready && !ack_q) begin
            if (lookup_hit) begin
              ack_q        <= 1'b1;
              rdata_q      <= mem_rdata;
              pf_addr_q    <= next_addr(addr);
              pf_pending_q <= 1'b1;
            end else if (!flash_busy) begin
              state_q      <= ST_ISSUE;
              flash_addr_q <= addr;
              flash_cs_q   <= 1'b1;
              demand_q     <= 1'b1;
            end
          end else if (!req && flash_ready && pf_pending_q && !flush) begin
            if (lookup_hit) begin
              pf_pending_q <= 1'b0;
            end else if (!flash_busy) begin
              state_q      <= ST_ISSUE;
              flash_addr_q <= pf_addr_q;
              flash_cs_q   <= 1'b1;
              demand_q     <= 1'b0;
              pf_pending_q <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          if (flash_busy) begin
            flash_cs_q <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The fill is written on this edge, so ack/rdata are already valid throughout FILL.
          if (!flash_busy) begin
            state_q <= ST_FILL;
            if (demand_q || fill_match) begin
              ack_q        <= 1'b1;
              rdata_q      <= flash_dout;
              pf_addr_q    <= next_addr(flash_addr_q);
              pf_pending_q <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          state_q  <= ST_IDLE;
          demand_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (flush) begin
        pf_pending_q <= 1'b0;
      end
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign flash_addr = flash_addr_q;
  assign flash_cs   = flash_cs_q;

endmodule

// File: tb/tb_flash_prefetch_cache.sv
// Self-checking bench: table of CPU reads against a behavioural flash model,
// with a scoreboard of expected read data popped on every ack.
module tb_flash_prefetch_cache;

  localparam int BUSY_CYC = 30;

  typedef struct {
    logic [21:0] addr;
    logic [15:0] data;
    bit          hit;
    bit          pf;
    logic [21:0] pf_addr;
    bit          flush_req;
    bit          flush_ack;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        req;
  logic [21:0] addr;
  logic        ack;
  logic [15:0] rdata;
  logic        flush;
  logic        flash_ready;
  logic        flash_busy;
  logic [15:0] flash_dout;
  logic [21:0] flash_addr;
  logic        flash_cs;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cs_rises = 0;
  int          cs_while_busy = 0;
  int          fall_cyc = 0;
  logic [21:0] last_cs_addr = '0;
  logic [15:0] exp_q[$];

  int          rises0;
  int          ackrise;
  int          lat;
  int          t_ack;
  bit          got;
  vec_t        vecs[12];
  vec_t        vr;

  flash_prefetch_cache dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .addr        (addr),
    .ack         (ack),
    .rdata       (rdata),
    .flush       (flush),
    .flash_ready (flash_ready),
    .flash_busy  (flash_busy),
    .flash_dout  (flash_dout),
    .flash_addr  (flash_addr),
    .flash_cs    (flash_cs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] flash_data(input logic [21:0] a);
    return a[15:0] ^ 16'hA4A5;
  endfunction

  // Flash controller model: starts on a cs rising edge, busy for BUSY_CYC cycles.
  initial begin
    logic        cs_prev;
    int          busy_left;
    logic [21:0] cur_addr;
    cs_prev    = 1'b0;
    busy_left  = 0;
    cur_addr   = '0;
    flash_busy = 1'b0;
    flash_dout = '0;
    forever begin
      @(negedge clk);
      if (flash_cs && !cs_prev) begin
        cs_rises++;
        last_cs_addr = flash_addr;
        if (flash_busy) cs_while_busy++;
        cur_addr   = flash_addr;
        flash_busy = 1'b1;
        busy_left  = BUSY_CYC;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          flash_busy = 1'b0;
          flash_dout = flash_data(cur_addr);
          fall_cyc   = cyc;
        end
      end
      cs_prev = flash_cs;
    end
  end

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_ack: got ack with rdata=%h, required no ack", rdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          n_fail++;
          $display("[TB] FAIL ack_rdata: got %h, required %h", rdata, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic settle();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 500) begin
      @(negedge clk);
      n++;
      if (flash_cs || flash_busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 4) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL settle_timeout: got flash still active, required idle");
    end
  endtask

  task automatic waitAck(input int limit);
    int n = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      flush = 1'b0;
      n++;
      if (ack) begin
        got   = 1'b1;
        t_ack = cyc;
      end
    end
    lat = n;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL ack_timeout addr=%h: got no ack in %0d cycles, required ack", addr, n);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit do_settle);
    if (do_settle) settle();
    rises0 = cs_rises;
    exp_q.push_back(v.data);
    req   = 1'b1;
    addr  = v.addr;
    flush = v.flush_req;
    waitAck(400);
    ackrise = cs_rises - rises0;
    req = 1'b0;
    if (got && v.flush_ack) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
  endtask

  task automatic checkOutput(input vec_t v);
    int pfrise;
    if (v.hit) begin
      compare($sformatf("hit_latency_%h", v.addr), lat, 1);
      compare($sformatf("hit_no_cs_%h", v.addr), ackrise, 0);
    end else begin
      compare($sformatf("miss_cs_count_%h", v.addr), ackrise, 1);
      compare($sformatf("miss_ack_after_busy_fall_%h", v.addr), t_ack - fall_cyc, 1);
    end
    settle();
    pfrise = cs_rises - rises0 - ackrise;
    compare($sformatf("prefetch_count_after_%h", v.addr), pfrise, v.pf ? 1 : 0);
    if (v.pf) compare($sformatf("prefetch_addr_after_%h", v.addr), last_cs_addr, v.pf_addr);
  endtask

  // A demand arrives while the prefetch that follows `first` is in flight.
  task automatic prefetchRace(input logic [21:0] first, input logic [21:0] pfa,
                              input logic [21:0] second);
    vec_t v;
    int   n = 0;
    int   r0;
    settle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    v = '{first, flash_data(first), 1'b0, 1'b1, pfa, 1'b0, 1'b0};
    applyStimulus(v, 1'b0);
    while (!flash_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    compare("race_prefetch_addr", flash_addr, pfa);
    @(negedge clk);
    r0 = cs_rises;
    exp_q.push_back(flash_data(second));
    req  = 1'b1;
    addr = second;
    waitAck(400);
    req = 1'b0;
    if (second == pfa) begin
      compare("race_match_no_new_cs", cs_rises - r0, 0);
      compare("race_match_ack_in_fill", t_ack - fall_cyc, 1);
    end else begin
      compare("race_other_one_new_cs", cs_rises - r0, 1);
      compare("race_other_ack_after_busy_fall", t_ack - fall_cyc, 1);
    end
    settle();
  endtask

  initial begin
    int n;
    req         = 1'b0;
    addr        = '0;
    flush       = 1'b0;
    flash_ready = 1'b0;
    resetn      = 1'b0;

    vecs[0]  = '{22'h000100, flash_data(22'h000100), 1'b0, 1'b1, 22'h000101, 1'b0, 1'b0};
    vecs[1]  = '{22'h000100, flash_data(22'h000100), 1'b1, 1'b0, 22'h000000, 1'b0, 1'b0};
    vecs[2]  = '{22'h000101, flash_data(22'h000101), 1'b1, 1'b1, 22'h000102, 1'b0, 1'b0};
    vecs[3]  = '{22'h000102, flash_data(22'h000102), 1'b1, 1'b1, 22'h000103, 1'b0, 1'b0};
    vecs[4]  = '{22'h000108, flash_data(22'h000108), 1'b0, 1'b1, 22'h000109, 1'b0, 1'b0};
    vecs[5]  = '{22'h000100, flash_data(22'h000100), 1'b0, 1'b1, 22'h000101, 1'b0, 1'b0};
    vecs[6]  = '{22'h3FFFFF, flash_data(22'h3FFFFF), 1'b0, 1'b1, 22'h000000, 1'b0, 1'b0};
    vecs[7]  = '{22'h000000, flash_data(22'h000000), 1'b1, 1'b1, 22'h000001, 1'b0, 1'b0};
    vecs[8]  = '{22'h3FFFFF, flash_data(22'h3FFFFF), 1'b1, 1'b0, 22'h000000, 1'b0, 1'b0};
    vecs[9]  = '{22'h000200, flash_data(22'h000200), 1'b0, 1'b0, 22'h000000, 1'b0, 1'b1};
    vecs[10] = '{22'h000200, flash_data(22'h000200), 1'b0, 1'b1, 22'h000201, 1'b0, 1'b0};
    vecs[11] = '{22'h000201, flash_data(22'h000201), 1'b0, 1'b1, 22'h000202, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    compare("reset_ack", ack, 0);
    compare("reset_flash_cs", flash_cs, 0);
    compare("reset_rdata", rdata, 0);
    compare("reset_flash_addr", flash_addr, 0);
    resetn = 1'b1;
    @(negedge clk);

    rises0 = cs_rises;
    req  = 1'b1;
    addr = 22'h000100;
    repeat (8) @(negedge clk);
    compare("not_ready_no_issue", cs_rises - rises0, 0);
    req = 1'b0;
    flash_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], 1'b1);
      checkOutput(vecs[i]);
    end

    prefetchRace(22'h0001FF, 22'h000200, 22'h000200);
    prefetchRace(22'h0001FF, 22'h000200, 22'h000300);

    // Reset while waiting on flash; the re-issue must wait for busy to drop.
    settle();
    req  = 1'b1;
    addr = 22'h000040;
    n = 0;
    while (!(flash_busy && !flash_cs) && n < 100) begin
      @(negedge clk);
      n++;
    end
    compare("reset_reached_wait", (n < 100) ? 1 : 0, 1);
    resetn = 1'b0;
    req    = 1'b0;
    @(negedge clk);
    compare("mid_reset_flash_cs", flash_cs, 0);
    compare("mid_reset_ack", ack, 0);
    resetn = 1'b1;
    vr = '{22'h000040, flash_data(22'h000040), 1'b0, 1'b1, 22'h000041, 1'b0, 1'b0};
    applyStimulus(vr, 1'b0);
    checkOutput(vr);

    compare("cs_rise_while_busy", cs_while_busy, 0);
    compare("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_prefetch_cache.md
FLASH_PREFETCH_CACHE -- requirements
Module: flash_prefetch_cache

Interface
REQ-001 Parameter IDX_BITS, default 3, log2 of cache entry count (8 direct-mapped 16-bit entries).
REQ-002 clk  in  1  system clock; the flash controller shares this clock.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 req  in  1  CPU read request; level, held until ack.
REQ-005 addr  in  22  CPU 16-bit word address.
REQ-006 ack  out  1  one-cycle pulse; rdata valid in the same cycle.
REQ-007 rdata  out  16  read data.
REQ-008 flush  in  1  one-cycle pulse; invalidates all entries.
REQ-009 flash_ready  in  1  flash init complete.
REQ-010 flash_busy  in  1  flash controller busy.
REQ-011 flash_dout  in  16  flash read data; valid once busy falls.
REQ-012 flash_addr  out  22  address driven to the flash controller.
REQ-013 flash_cs  out  1  read strobe to the flash controller; the controller triggers on its rising edge.

Function
REQ-014 Entry index = addr[IDX_BITS-1:0].
REQ-015 Each entry holds one valid bit, a tag = addr[21:IDX_BITS], and 16 data bits.
REQ-016 States are IDLE, ISSUE, WAIT and FILL.
REQ-017 In IDLE with req=1 and flash_ready=1, the block samples addr.
REQ-018 On a hit, ack=1 and rdata=entry data in the next cycle; state stays IDLE.
REQ-019 On a miss, the block goes to ISSUE with flash_addr=addr and demand flag=1.
REQ-020 ISSUE: flash_cs=1 and flash_addr is held stable until flash_busy=1 is sampled, then flash_cs=0 and the block goes to WAIT.
REQ-021 WAIT: the block stays until flash_busy=0, then goes to FILL.
REQ-022 FILL (one cycle): writes flash_dout into the entry for flash_addr and sets it valid; if demand flag=1, ack=1 with rdata=flash_dout; then goes to IDLE.
REQ-023 Prefetch: after each demand completion (hit or fill), pf_addr = served addr + 1, wrapping 22'h3FFFFF to 22'h000000, and pf_pending is set.
REQ-024 In IDLE with req=0 and pf_pending=1: if pf_addr hits, pf_pending clears; otherwise the block goes to ISSUE with demand flag=0 and flash_addr=pf_addr.
REQ-025 A demand req has priority over a pending prefetch in IDLE.
REQ-026 A req arriving during a prefetch waits. In FILL, if the sampled request address equals flash_addr, ack is issued in FILL; otherwise the request is handled from IDLE on the next cycle.
REQ-027 Prefetch issue clears pf_pending; no chained prefetch without a new demand.
REQ-028 With flash_ready=0, no request is accepted and no prefetch is issued.
REQ-029 flush clears all valid bits and pf_pending in one cycle.
REQ-030 flush in the same cycle as FILL: the data is still acked if it is a demand, but the entry is left invalid (flush wins).
REQ-031 flush with req in IDLE: the lookup treats the cache as empty.
REQ-032 At most one ack per accepted req; ack never asserts without an accepted req.
REQ-033 Hit latency is 1 cycle; miss latency is flash latency + 3 cycles.

Reset
REQ-034 On resetn low: state=IDLE, ack=0, flash_cs=0, rdata=0, flash_addr=0, all valid bits=0, pf_pending=0, demand flag=0.
REQ-035 Reset mid-ISSUE/WAIT abandons the transaction; after release, the block waits for flash_busy=0 before the next issue.
REQ-036 Cache data RAM is not reset.

Structure
REQ-037 A shared package holds the state enum, ADDR_W=22, DATA_W=16 and the IDX_BITS default.
REQ-038 One sub-module, flash_cache_mem: tag/valid/data array with 1 write and 1 async read port, plus flush-clear.

Verification
REQ-039 Reset, flash_ready=1, req addr=22'h000100 (miss; flash model busy 30 cycles, data 16'hA5A5) -> one flash_cs rise; ack with 16'hA5A5 at busy fall + 1 cycle.
REQ-040 Same addr 22'h000100 requested again -> ack 1 cycle after sampling, no flash_cs.
REQ-041 After REQ-039, req idle -> prefetch flash_addr=22'h000101; a later req for 22'h000101 hits with no new flash_cs.
REQ-042 req addr=22'h3FFFFF -> prefetch flash_addr=22'h000000.
REQ-043 flush pulsed during FILL of a demand read -> ack still given; the same addr next -> miss, new flash_cs.
REQ-044 req for 22'h000200 while prefetching 22'h000200 -> ack in FILL; req for 22'h000300 during that prefetch -> served after the prefetch, with exactly one ack.
